// File: rtl/wbuf_id_alloc_pkg.sv
// Shared configuration types for the write-buffer ID allocator.
//   mpc_cfg_t     : block configuration; u.wbufSize is the number of write-buffer entries.
//   MpcCfgDefault : 4-entry configuration used when no Cfg override is given.
//   ptr_w()       : width of a pointer that addresses 0..n-1 (at least 1 bit).
package wbuf_id_alloc_pkg;

  typedef struct packed {
    int unsigned wbufSize;
  } mpc_u_cfg_t;

  typedef struct packed {
    mpc_u_cfg_t u;
  } mpc_cfg_t;

  localparam mpc_cfg_t MpcCfgDefault = '{u: '{wbufSize: 32'd4}};

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wbuf_id_alloc.sv
// Free-list allocator for write-buffer entry IDs.
// IDs live in a circular queue (head = next to grant, tail = next return slot) with a busy
// bitmap that validates returns. Grants are combinational from registers; returns become
// grantable the following cycle, in FIFO order of return.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   alloc_valid  : requester wants an ID this cycle
//   alloc_ready  : an ID is available (free_cnt != 0)
//   alloc_id     : ID granted on alloc_valid && alloc_ready
//   free_valid   : write buffer returns free_id (xbar_rsp_free_valid / xbar_rsp_free_id)
//   free_cnt     : number of free IDs
//   all_free     : free_cnt == N
//   err_valid    : one-cycle pulse, the free of the previous cycle was rejected
//   err_id       : ID of the rejected free
module wbuf_id_alloc
  import wbuf_id_alloc_pkg::*;
#(
  parameter mpc_cfg_t Cfg = MpcCfgDefault,
  localparam int unsigned N    = Cfg.u.wbufSize,
  // One value beyond N-1 must be representable so out-of-range frees can be reported.
  localparam int unsigned IdW  = $clog2(N + 1),
  localparam int unsigned CntW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  output logic [IdW-1:0]  alloc_id,
  input  logic            free_valid,
  input  logic [IdW-1:0]  free_id,
  output logic [CntW-1:0] free_cnt,
  output logic            all_free,
  output logic            err_valid,
  output logic [IdW-1:0]  err_id
);

  localparam int unsigned PtrW = ptr_w(N);

  typedef logic [IdW-1:0]  wbufWidth_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam ptr_t LastPtr = ptr_t'(N - 1);
  localparam cnt_t FullCnt = cnt_t'(N);

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  wbufWidth_t   q_q [N];
  wbufWidth_t   q_d [N];
  ptr_t         head_q, head_d;
  ptr_t         tail_q, tail_d;
  logic [N-1:0] busy_q, busy_d;
  cnt_t         cnt_q, cnt_d;
  logic         err_valid_q;
  wbufWidth_t   err_id_q, err_id_d;

  logic alloc_fire;
  logic free_in_range;
  logic busy_hit;
  logic free_accept;
  logic free_reject;

  assign alloc_ready = (cnt_q != '0);
  assign alloc_id    = q_q[head_q];
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign free_cnt    = cnt_q;
  assign all_free    = (cnt_q == FullCnt);
  assign err_valid   = err_valid_q;
  assign err_id      = err_id_q;

  // The check uses the pre-edge bitmap, so freeing the ID being granted this same cycle
  // sees it not-yet-busy and is rejected.
  always_comb begin
    busy_hit = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (free_id == wbufWidth_t'(i)) busy_hit = busy_q[i];
    end
  end

  assign free_in_range = (free_id < wbufWidth_t'(N));
  assign free_accept   = free_valid && free_in_range && busy_hit;
  assign free_reject   = free_valid && !free_accept;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    err_id_d = err_id_q;
    for (int unsigned i = 0; i < N; i++) q_d[i] = q_q[i];

    if (alloc_fire) head_d = ptr_inc(head_q);

    if (free_accept) begin
      q_d[tail_q] = free_id;
      tail_d      = ptr_inc(tail_q);
    end

    // Granted and returned IDs are always distinct bits (see busy_hit).
    for (int unsigned i = 0; i < N; i++) begin
      if (alloc_fire && (alloc_id == wbufWidth_t'(i))) busy_d[i] = 1'b1;
      if (free_accept && (free_id == wbufWidth_t'(i))) busy_d[i] = 1'b0;
    end

    unique case ({free_accept, alloc_fire})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase

    if (free_reject) err_id_d = free_id;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) q_q[i] <= wbufWidth_t'(i);
      head_q      <= '0;
      tail_q      <= '0;
      busy_q      <= '0;
      cnt_q       <= FullCnt;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) q_q[i] <= q_d[i];
      head_q      <= head_d;
      tail_q      <= tail_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      err_valid_q <= free_reject;
      err_id_q    <= err_id_d;
    end
  end

  // Counter must never wrap in either direction.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(alloc_fire && !free_accept && (cnt_q == '0)));
      assert (!(free_accept && !alloc_fire && (cnt_q == FullCnt)));
    end
  end

endmodule

// File: tb/tb_wbuf_id_alloc.sv
// Self-checking bench for wbuf_id_alloc with a 4-entry pool.
// Each vector drives one cycle of inputs and checks the outputs visible in that cycle
// (i.e. the state left by all previous vectors).
module tb_wbuf_id_alloc;
  import wbuf_id_alloc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [2:0] alloc_id;
  logic       free_valid;
  logic [2:0] free_id;
  logic [2:0] free_cnt;
  logic       all_free;
  logic       err_valid;
  logic [2:0] err_id;

  int checks = 0;
  int errors = 0;

  wbuf_id_alloc #(
    .Cfg(MpcCfgDefault)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_valid(alloc_valid),
    .alloc_ready(alloc_ready),
    .alloc_id   (alloc_id),
    .free_valid (free_valid),
    .free_id    (free_id),
    .free_cnt   (free_cnt),
    .all_free   (all_free),
    .err_valid  (err_valid),
    .err_id     (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  typedef struct {
    logic       chk;
    logic       rst_n;
    logic       av;
    logic       fv;
    logic [2:0] fid;
    logic       rdy;
    logic [2:0] id;
    logic [2:0] cnt;
    logic       err;
    logic [2:0] eid;
  } vec_t;

  vec_t tab_a [13];
  vec_t tab_b [21];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    @(negedge clk);
    rst_n       = v.rst_n;
    alloc_valid = v.av;
    free_valid  = v.fv;
    free_id     = v.fid;
    #1;
    if (v.chk) begin
      check($sformatf("%s[%0d].alloc_ready", tag, idx), int'(alloc_ready), int'(v.rdy));
      if (v.rdy) check($sformatf("%s[%0d].alloc_id", tag, idx), int'(alloc_id), int'(v.id));
      check($sformatf("%s[%0d].free_cnt", tag, idx), int'(free_cnt), int'(v.cnt));
      check($sformatf("%s[%0d].all_free", tag, idx), int'(all_free), int'(v.cnt == 3'd4));
      check($sformatf("%s[%0d].err_valid", tag, idx), int'(err_valid), int'(v.err));
      if (v.err) check($sformatf("%s[%0d].err_id", tag, idx), int'(err_id), int'(v.eid));
    end
  endtask

  int pool[$];
  int outstanding[$];
  int exp_id;
  int old_id;

  initial begin
    rst_n       = 1'b0;
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    free_id     = '0;

    //            chk rst av fv fid rdy id cnt err eid
    // Reset, then four back-to-back allocs drain the pool.
    tab_a[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tab_a[1]  = '{1, 1, 0, 0, 0, 1, 0, 4, 0, 0};
    tab_a[2]  = '{1, 1, 1, 0, 0, 1, 0, 4, 0, 0};
    tab_a[3]  = '{1, 1, 1, 0, 0, 1, 1, 3, 0, 0};
    tab_a[4]  = '{1, 1, 1, 0, 0, 1, 2, 2, 0, 0};
    tab_a[5]  = '{1, 1, 1, 0, 0, 1, 3, 1, 0, 0};
    // Empty: alloc held, free 2 then 0; grants follow return order.
    tab_a[6]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    tab_a[7]  = '{1, 1, 1, 1, 2, 0, 0, 0, 0, 0};
    tab_a[8]  = '{1, 1, 1, 1, 0, 1, 2, 1, 0, 0};
    tab_a[9]  = '{1, 1, 1, 0, 0, 1, 0, 1, 0, 0};
    tab_a[10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    // Return 1 and 3 to reach free_cnt = 2 (pool order 1, 3).
    tab_a[11] = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
    tab_a[12] = '{1, 1, 0, 1, 3, 1, 1, 1, 0, 0};

    // Reset, double free, out-of-range, full-pool free, same-ID alloc+free, reset mid-flight.
    tab_b[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tab_b[1]  = '{1, 1, 0, 0, 0, 1, 0, 4, 0, 0};
    tab_b[2]  = '{1, 1, 1, 0, 0, 1, 0, 4, 0, 0};
    tab_b[3]  = '{1, 1, 0, 1, 0, 1, 1, 3, 0, 0};
    tab_b[4]  = '{1, 1, 0, 1, 0, 1, 1, 4, 0, 0};
    tab_b[5]  = '{1, 1, 0, 0, 0, 1, 1, 4, 1, 0};
    tab_b[6]  = '{1, 1, 0, 0, 0, 1, 1, 4, 0, 0};
    tab_b[7]  = '{1, 1, 0, 1, 5, 1, 1, 4, 0, 0};
    tab_b[8]  = '{1, 1, 0, 0, 0, 1, 1, 4, 1, 5};
    tab_b[9]  = '{1, 1, 0, 0, 0, 1, 1, 4, 0, 0};
    tab_b[10] = '{1, 1, 0, 1, 2, 1, 1, 4, 0, 0};
    tab_b[11] = '{1, 1, 0, 0, 0, 1, 1, 4, 1, 2};
    tab_b[12] = '{1, 1, 1, 1, 1, 1, 1, 4, 0, 0};
    tab_b[13] = '{1, 1, 0, 0, 0, 1, 2, 3, 1, 1};
    tab_b[14] = '{1, 1, 1, 0, 0, 1, 2, 3, 0, 0};
    tab_b[15] = '{1, 1, 1, 0, 0, 1, 3, 2, 0, 0};
    tab_b[16] = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    tab_b[17] = '{1, 1, 0, 0, 0, 1, 0, 4, 0, 0};
    tab_b[18] = '{1, 1, 0, 1, 1, 1, 0, 4, 0, 0};
    tab_b[19] = '{1, 1, 0, 0, 0, 1, 0, 4, 1, 1};
    tab_b[20] = '{1, 1, 0, 0, 0, 1, 0, 4, 0, 0};

    for (int i = 0; i < 13; i++) run_vec("a", i, tab_a[i]);

    // Steady state: alloc and free every cycle for 20 cycles, free_cnt stays 2.
    // Free pool (grant order) is 1, 3; outstanding IDs are 0, 2.
    pool        = '{1, 3};
    outstanding = '{0, 2};
    for (int c = 0; c < 20; c++) begin
      exp_id = pool.pop_front();
      old_id = outstanding.pop_front();
      @(negedge clk);
      alloc_valid = 1'b1;
      free_valid  = 1'b1;
      free_id     = 3'(old_id);
      #1;
      check($sformatf("steady[%0d].alloc_ready", c), int'(alloc_ready), 1);
      check($sformatf("steady[%0d].alloc_id", c), int'(alloc_id), exp_id);
      check($sformatf("steady[%0d].free_cnt", c), int'(free_cnt), 2);
      check($sformatf("steady[%0d].err_valid", c), int'(err_valid), 0);
      pool.push_back(old_id);
      outstanding.push_back(exp_id);
    end
    @(negedge clk);
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    #1;
    check("steady_end.free_cnt", int'(free_cnt), 2);
    check("steady_end.err_valid", int'(err_valid), 0);
    check("steady_end.alloc_id", int'(alloc_id), pool[0]);

    for (int i = 0; i < 21; i++) run_vec("b", i, tab_b[i]);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
